dense_sequencer: RTL and testbench

Sequencer for the three-layer dense classifier of the speech-recognition network. It runs one inference on `start`. For each layer in turn it produces accumulator clear, per-input MAC enable and input index, ReLU and store strobes. It sits between the feature buffer, which supplies layer-1 inputs with a valid flag, and the dense-layer datapath, which owns the weights, accumulators and inter-layer buffers.

---
 rtl/dense_sequencer.sv | 129 ++++++++++++
 tb/tb_dense_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dense_sequencer.sv
// Control sequencer for the three-layer dense classifier: walks each layer through
// clear, multiply-accumulate over its inputs, optional ReLU and store, then signals done.
module dense_sequencer #(
  parameter int IN_SIZE_1 = 64,
  parameter int IN_SIZE_2 = 32,
  parameter int IN_SIZE_3 = 16,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             busy,
  output logic [1:0]       layer_sel,
  output logic             acc_clr,
  output logic             mac_en,
  output logic [IDX_W-1:0] in_idx,
  output logic             relu_en,
  output logic             store_en,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_RELU,
    S_STORE,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_1 = IDX_W'(IN_SIZE_1 - 1);
  localparam logic [IDX_W-1:0] LAST_2 = IDX_W'(IN_SIZE_2 - 1);
  localparam logic [IDX_W-1:0] LAST_3 = IDX_W'(IN_SIZE_3 - 1);

  state_t           state, state_nxt;
  logic [1:0]       layer, layer_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W-1:0] last_idx;
  logic             step;

  // Last input index of whichever layer is currently active.
  always_comb begin
    case (layer)
      2'd1:    last_idx = LAST_1;
      2'd2:    last_idx = LAST_2;
      default: last_idx = LAST_3;
    endcase
  end

  // Only layer 1 reads the external feature buffer; later layers read internal buffers.
  assign step = (layer != 2'd1) || in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      layer <= 2'd0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      layer <= layer_nxt;
      idx   <= idx_nxt;
    end
  end

  // The index wraps to 0 on the final MAC step so that it only ever moves on mac_en edges.
  always_comb begin
    state_nxt = state;
    layer_nxt = layer;
    idx_nxt   = idx;
    acc_clr   = 1'b0;
    mac_en    = 1'b0;
    relu_en   = 1'b0;
    store_en  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLEAR;
          layer_nxt = 2'd1;
        end
      end
      S_CLEAR: begin
        acc_clr   = 1'b1;
        state_nxt = S_MAC;
        idx_nxt   = '0;
      end
      S_MAC: begin
        if (step) begin
          mac_en = 1'b1;
          if (idx == last_idx) begin
            idx_nxt   = '0;
            state_nxt = (layer == 2'd3) ? S_STORE : S_RELU;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      S_RELU: begin
        relu_en   = 1'b1;
        state_nxt = S_STORE;
      end
      S_STORE: begin
        store_en = 1'b1;
        if (layer == 2'd3) begin
          state_nxt = S_DONE;
          layer_nxt = 2'd0;
        end else begin
          state_nxt = S_CLEAR;
          layer_nxt = layer + 2'd1;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        layer_nxt = 2'd0;
        idx_nxt   = '0;
      end
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign layer_sel = layer;
  assign in_idx    = idx;

endmodule

// File: tb/tb_dense_sequencer.sv
// Scoreboard bench for dense_sequencer: builds a cycle-by-cycle plan of inputs and
// expected outputs from the layer timing, drives it and compares every cycle.
module tb_dense_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic       busy, acc_clr, mac_en, relu_en, store_en, done;
  logic [1:0] layer_sel;
  logic [7:0] in_idx;
  logic       rst_s, start_s, in_valid_s;
  logic       busy_s, acc_clr_s, mac_en_s, relu_en_s, store_en_s, done_s;
  logic [1:0] layer_sel_s;
  logic [7:0] in_idx_s;

  always #5 clk = ~clk;

  dense_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .busy(busy), .layer_sel(layer_sel), .acc_clr(acc_clr), .mac_en(mac_en),
    .in_idx(in_idx), .relu_en(relu_en), .store_en(store_en), .done(done)
  );

  dense_sequencer #(.IN_SIZE_1(1), .IN_SIZE_2(1), .IN_SIZE_3(1), .IDX_W(8)) dut_small (
    .clk(clk), .rst(rst_s), .start(start_s), .in_valid(in_valid_s),
    .busy(busy_s), .layer_sel(layer_sel_s), .acc_clr(acc_clr_s), .mac_en(mac_en_s),
    .in_idx(in_idx_s), .relu_en(relu_en_s), .store_en(store_en_s), .done(done_s)
  );

  typedef struct packed {
    logic       sel;
    logic       start;
    logic       rst;
    logic       inv;
    logic       idx_chk;
    logic       busy;
    logic [1:0] layer;
    logic       clr;
    logic       mac;
    logic       relu;
    logic       store;
    logic       done;
    logic [7:0] idx;
  } rec_t;

  rec_t plan_q[$];
  rec_t exp_q[$];
  int   stall_q[$];
  int   gen_off, gen_start_mode, gen_abort;
  bit   gen_aborted;
  int   exp_runs = 0, exp_l1_mac = 0;
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, done_cnt = 0, l1_mac_cnt = 0;
  rec_t e;
  logic [15:0] obs_v, exp_v;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("[TB] FAIL %s at plan cycle %0d: got %h, expected %h", tag, cyc, obs, expv);
    end
  endtask

  function automatic bit is_stall(input int n);
    foreach (stall_q[i]) if (stall_q[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic rec_t base_rec(input logic sel, input logic [1:0] layer);
    rec_t r;
    r       = '0;
    r.sel   = sel;
    r.busy  = 1'b1;
    r.layer = layer;
    r.inv   = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Start and reset inputs during a run depend on the scenario and the cycle offset from k.
  task automatic emit(input rec_t r_in);
    rec_t r;
    r       = r_in;
    r.start = (gen_start_mode == 1) || (gen_start_mode == 2 && gen_off == 50);
    r.rst   = (gen_abort != 0) && (gen_off == gen_abort);
    plan_q.push_back(r);
    gen_aborted = r.rst;
    gen_off++;
  endtask

  task automatic gen_idle(input logic sel, input int n, input logic st, input logic ichk);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r         = '0;
      r.sel     = sel;
      r.start   = st;
      r.inv     = 1'($urandom_range(0, 1));
      r.idx_chk = ichk;
      plan_q.push_back(r);
    end
  endtask

  task automatic gen_run(input logic sel, input int n1, input int n2, input int n3,
                         input int mode, input int abort_off);
    rec_t r;
    int   sizes[3];
    int   macc;
    int   idx;
    sizes[0] = n1; sizes[1] = n2; sizes[2] = n3;
    macc = 0;
    gen_off = 1; gen_start_mode = mode; gen_abort = abort_off; gen_aborted = 0;
    for (int l = 1; l <= 3; l++) begin
      r = base_rec(sel, 2'(l)); r.clr = 1'b1;
      emit(r); if (gen_aborted) return;
      idx = 0;
      while (idx < sizes[l-1]) begin
        r = base_rec(sel, 2'(l));
        if (l == 1) begin
          r.inv = !is_stall(macc);
          macc++;
        end
        r.mac     = (l != 1) || r.inv;
        r.idx_chk = 1'b1;
        r.idx     = 8'(idx);
        if (r.mac) begin
          idx++;
          if (l == 1) exp_l1_mac++;
        end
        emit(r); if (gen_aborted) return;
      end
      if (l < 3) begin
        r = base_rec(sel, 2'(l)); r.relu = 1'b1;
        emit(r); if (gen_aborted) return;
      end
      r = base_rec(sel, 2'(l)); r.store = 1'b1;
      emit(r); if (gen_aborted) return;
    end
    r = base_rec(sel, 2'd0); r.done = 1'b1;
    emit(r);
    exp_runs++;
  endtask

  task automatic applyStimulus(input rec_t r);
    start      = r.sel ? 1'b0 : r.start;
    rst        = r.sel ? 1'b0 : r.rst;
    in_valid   = r.sel ? 1'b0 : r.inv;
    start_s    = r.sel ? r.start : 1'b0;
    rst_s      = r.sel ? r.rst : 1'b0;
    in_valid_s = r.sel ? r.inv : 1'b0;
    exp_q.push_back(r);
  endtask

  // Compare every planned cycle mid-period, and tally done pulses and layer-1 MAC steps.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cyc++;
      if (e.sel)
        obs_v = {busy_s, layer_sel_s, acc_clr_s, mac_en_s, relu_en_s, store_en_s, done_s, in_idx_s};
      else
        obs_v = {busy, layer_sel, acc_clr, mac_en, relu_en, store_en, done, in_idx};
      exp_v = {e.busy, e.layer, e.clr, e.mac, e.relu, e.store, e.done, e.idx};
      if (!e.idx_chk) obs_v[7:0] = 8'h00;
      checkOutput("outputs", 32'(obs_v), 32'(exp_v));
    end
    if (done === 1'b1) done_cnt++;
    if (done_s === 1'b1) done_cnt++;
    if (mac_en === 1'b1 && layer_sel === 2'd1) l1_mac_cnt++;
    if (mac_en_s === 1'b1 && layer_sel_s === 2'd1) l1_mac_cnt++;
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    rst_s = 1'b1; start_s = 1'b0; in_valid_s = 1'b0;

    gen_idle(0, 3, 1'b0, 1'b1);
    gen_idle(0, 1, 1'b1, 1'b1);
    gen_run(0, 64, 32, 16, 0, 0);
    gen_idle(0, 2, 1'b0, 1'b0);

    stall_q = '{3, 10, 11, 30, 60};
    gen_idle(0, 1, 1'b1, 1'b0);
    gen_run(0, 64, 32, 16, 0, 0);
    stall_q.delete();
    gen_idle(0, 2, 1'b0, 1'b0);

    gen_idle(0, 1, 1'b1, 1'b0);
    gen_run(0, 64, 32, 16, 2, 0);
    gen_idle(0, 3, 1'b0, 1'b0);

    gen_idle(0, 1, 1'b1, 1'b0);
    gen_run(0, 64, 32, 16, 1, 0);
    gen_idle(0, 1, 1'b1, 1'b0);
    gen_run(0, 64, 32, 16, 1, 0);
    gen_idle(0, 2, 1'b0, 1'b0);

    gen_idle(0, 1, 1'b1, 1'b0);
    gen_run(0, 64, 32, 16, 0, 80);
    gen_idle(0, 1, 1'b0, 1'b1);
    gen_idle(0, 1, 1'b1, 1'b1);
    gen_run(0, 64, 32, 16, 0, 0);
    gen_idle(0, 2, 1'b0, 1'b0);

    gen_idle(1, 2, 1'b0, 1'b1);
    stall_q = '{0};
    gen_idle(1, 1, 1'b1, 1'b1);
    gen_run(1, 1, 1, 1, 0, 0);
    stall_q.delete();
    gen_idle(1, 2, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    foreach (plan_q[i]) begin
      #1;
      applyStimulus(plan_q[i]);
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    checkOutput("done_count", 32'(done_cnt), 32'(exp_runs));
    checkOutput("l1_mac_count", 32'(l1_mac_cnt), 32'(exp_l1_mac));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
